online_div_residue_stage: RTL and testbench

- Parametrised radix-2 online-division residue stage. Successor to the fixed-width stage-two residue register, which only holds a zeroed residue.
- Holds the residue at a configurable width and runs the residual recurrence one signed input digit per step.
- Selects a quotient digit every step and exposes the residue as plus/minus (sign-magnitude) pairs, split into upper and lower fields.
- Has start/clear control and valid/ready handshakes on both input and output.

---
 rtl/online_div_residue_stage.sv | 163 ++++++++++++++++
 tb/tb_online_div_residue_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/online_div_residue_stage.sv
// Radix-2 online-division residue stage: one signed dividend digit per step,
// one quotient digit out, residue exposed as registered sign-magnitude pairs.
module online_div_residue_stage #(
  parameter int LW      = 4,
  parameter int UW      = 6,
  parameter int NDIGITS = 8,
  parameter int XPOS    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      start,
  input  logic signed [LW+UW-1:0]   divisor,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      x_plus,
  input  logic                      x_minus,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      q_plus,
  output logic                      q_minus,
  output logic                      out_last,
  output logic [LW-1:0]             residue_plus,
  output logic [LW-1:0]             residue_minus,
  output logic [UW-1:0]             residue_upper_plus,
  output logic [UW-1:0]             residue_upper_minus,
  output logic                      busy,
  output logic                      ovf
);

  localparam int W  = LW + UW;
  localparam int VW = W + 2;
  localparam logic signed [VW-1:0] X_WEIGHT   = VW'(1) << XPOS;
  localparam logic [7:0]           LAST_COUNT = 8'(NDIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic signed [W-1:0]  r_q, d_q;
  logic [W-1:0]         p_q, m_q;
  logic [7:0]           count;

  logic signed [VW-1:0] r_ext, d_ext, x_term, v, t, r_next;
  logic signed [W-1:0]  r_wrap;
  logic [W-1:0]         r_mag;
  logic                 sel_plus, sel_minus, step_ovf, step, last_step;

  assign r_ext = {{2{r_q[W-1]}}, r_q};
  assign d_ext = {{2{d_q[W-1]}}, d_q};

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    x_term = '0;
    if (x_plus && !x_minus)
      x_term = X_WEIGHT;
    else if (x_minus && !x_plus)
      x_term = -X_WEIGHT;
    v         = (r_ext <<< 1) + x_term;
    t         = d_ext >>> 1;
    sel_plus  = (v >= t);
    sel_minus = !sel_plus && (v < -t);
    r_next    = v;
    if (sel_plus)
      r_next = v - d_ext;
    else if (sel_minus)
      r_next = v + d_ext;
  end

  // Out of range when the guard bits are not a pure sign extension.
  assign step_ovf  = !((&r_next[VW-1:W-1]) || !(|r_next[VW-1:W-1]));
  assign r_wrap    = r_next[W-1:0];
  assign r_mag     = ~r_wrap + 1'b1;

  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign step      = in_valid && in_ready;
  assign last_step = step && (count == LAST_COUNT);
  assign busy      = (state != IDLE);

  assign residue_plus        = p_q[LW-1:0];
  assign residue_minus       = m_q[LW-1:0];
  assign residue_upper_plus  = p_q[W-1:LW];
  assign residue_upper_minus = m_q[W-1:LW];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_valid && out_ready && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear)
      state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      d_q       <= '0;
      p_q       <= '0;
      m_q       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      q_plus    <= 1'b0;
      q_minus   <= 1'b0;
      ovf       <= 1'b0;
    end else if (clear) begin
      // Abort keeps the divisor and the sticky overflow for inspection.
      r_q       <= '0;
      p_q       <= '0;
      m_q       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      q_plus    <= 1'b0;
      q_minus   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        d_q   <= divisor;
        r_q   <= '0;
        p_q   <= '0;
        m_q   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end
      if (step) begin
        r_q       <= r_wrap;
        if (r_wrap[W-1]) begin
          p_q <= '0;
          m_q <= r_mag;
        end else begin
          p_q <= r_wrap;
          m_q <= '0;
        end
        q_plus    <= sel_plus;
        q_minus   <= sel_minus;
        out_valid <= 1'b1;
        out_last  <= last_step;
        count     <= count + 8'd1;
        if (step_ovf)
          ovf <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        q_plus    <= 1'b0;
        q_minus   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_online_div_residue_stage.sv
// Self-checking bench for online_div_residue_stage: directed vector table,
// hand-written corner sequences, and randomized runs against an integer model.
module tb_online_div_residue_stage;

  localparam int LW      = 4;
  localparam int UW      = 6;
  localparam int W       = LW + UW;
  localparam int NDIGITS = 8;
  localparam int XPOS    = 4;

  logic                 clk, rst, clear, start;
  logic signed [W-1:0]  divisor;
  logic                 in_valid, in_ready, x_plus, x_minus;
  logic                 out_valid, out_ready, q_plus, q_minus, out_last;
  logic [LW-1:0]        residue_plus, residue_minus;
  logic [UW-1:0]        residue_upper_plus, residue_upper_minus;
  logic                 busy, ovf;

  online_div_residue_stage #(
    .LW(LW), .UW(UW), .NDIGITS(NDIGITS), .XPOS(XPOS)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .divisor(divisor),
    .in_valid(in_valid), .in_ready(in_ready), .x_plus(x_plus), .x_minus(x_minus),
    .out_valid(out_valid), .out_ready(out_ready), .q_plus(q_plus), .q_minus(q_minus),
    .out_last(out_last), .residue_plus(residue_plus), .residue_minus(residue_minus),
    .residue_upper_plus(residue_upper_plus), .residue_upper_minus(residue_upper_minus),
    .busy(busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit restart;
    int d;
    bit xp;
    bit xm;
    int exp_q;
    int exp_r;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Wrap an integer into the W-bit two's complement range.
  function automatic int wrap_w(input int x);
    int m;
    m = (x + (1 << (W - 1))) % (1 << W);
    if (m < 0) m += (1 << W);
    return m - (1 << (W - 1));
  endfunction

  // One recurrence step straight from the arithmetic rules.
  function automatic void model_step(input int d, input int xv, inout int r,
                                     inout int ov, output int q);
    int v, t, rn;
    v = 2 * r + xv * (1 << XPOS);
    t = d >>> 1;
    if (v >= t)       q = 1;
    else if (v < -t)  q = -1;
    else              q = 0;
    rn = v - q * d;
    if (rn > (1 << (W - 1)) - 1 || rn < -(1 << (W - 1))) ov = 1;
    r = wrap_w(rn);
  endfunction

  task automatic check_residue(input string tag, input int r);
    int p, m;
    p = (r >= 0) ? r : 0;
    m = (r < 0) ? -r : 0;
    check({tag, " residue_plus"},        residue_plus,        p % (1 << LW));
    check({tag, " residue_upper_plus"},  residue_upper_plus,  p / (1 << LW));
    check({tag, " residue_minus"},       residue_minus,       m % (1 << LW));
    check({tag, " residue_upper_minus"}, residue_upper_minus, m / (1 << LW));
  endtask

  task automatic check_q(input string tag, input int expq);
    check({tag, " q"}, int'(q_plus) - int'(q_minus), expq);
    check({tag, " q_exclusive"}, int'(q_plus & q_minus), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_start(input int d);
    divisor = d[W-1:0];
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Present one digit with out_ready high and wait (bounded) for acceptance.
  task automatic do_step(input bit xp, input bit xm);
    int n;
    in_valid  = 1'b1;
    x_plus    = xp;
    x_minus   = xm;
    out_ready = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("step in_ready timeout", 0, 1);
    end else begin
      tick();
      check("step out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    x_plus   = 1'b0;
    x_minus  = 1'b0;
  endtask

  vec_t vecs[8];
  int   r_dir[6];

  initial begin
    vecs[0] = '{1, 128, 1, 0,  0,  16};
    vecs[1] = '{0, 128, 1, 0,  0,  48};
    vecs[2] = '{0, 128, 1, 0,  1, -16};
    vecs[3] = '{0, 128, 1, 0,  0, -16};
    vecs[4] = '{1, 128, 0, 1,  0, -16};
    vecs[5] = '{0, 128, 0, 1,  0, -48};
    vecs[6] = '{0, 128, 0, 1, -1,  16};
    vecs[7] = '{0, 128, 1, 1,  0,  32};
    r_dir   = '{16, 48, 112, 240, 496, -16};

    rst = 1'b1; clear = 1'b0; start = 1'b0; divisor = '0;
    in_valid = 1'b0; x_plus = 1'b0; x_minus = 1'b0; out_ready = 1'b0;

    // Reset
    tick();
    tick();
    check_residue("reset", 0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 0);
    check("reset busy", busy, 0);
    check("reset ovf", ovf, 0);
    check("reset out_last", out_last, 0);
    rst = 1'b0;
    tick();

    // Directed vectors: positive digits, negative digits, both-set digit
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].restart) begin
        do_clear();
        do_start(vecs[i].d);
        check($sformatf("vec%0d busy after start", i), busy, 1);
      end
      do_step(vecs[i].xp, vecs[i].xm);
      check_q($sformatf("vec%0d", i), vecs[i].exp_q);
      check_residue($sformatf("vec%0d", i), vecs[i].exp_r);
      check($sformatf("vec%0d ovf", i), ovf, 0);
    end

    // Backpressure: output held, then released with a same-edge new step
    do_clear();
    do_start(0);
    in_valid = 1'b1; x_plus = 1'b1; x_minus = 1'b0; out_ready = 1'b0;
    #1;
    check("bp in_ready initial", in_ready, 1);
    tick();
    check("bp out_valid", out_valid, 1);
    check_q("bp first", 1);
    check_residue("bp first", 16);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp hold%0d in_ready", i), in_ready, 0);
      check($sformatf("bp hold%0d out_valid", i), out_valid, 1);
      check_q($sformatf("bp hold%0d", i), 1);
      check_residue($sformatf("bp hold%0d", i), 16);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", in_ready, 1);
    tick();
    check("bp no bubble out_valid", out_valid, 1);
    check_q("bp second", 1);
    check_residue("bp second", 48);
    in_valid = 1'b0; x_plus = 1'b0;

    // Length and last marker
    do_clear();
    do_start(128);
    for (int i = 0; i < NDIGITS; i++) begin
      do_step(0, 0);
      check_q($sformatf("len%0d", i), 0);
      check($sformatf("len%0d out_last", i), out_last, (i == NDIGITS - 1) ? 1 : 0);
    end
    out_ready = 1'b0; in_valid = 1'b1; x_plus = 1'b1;
    #1;
    check("len extra in_ready", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("len hold%0d out_valid", i), out_valid, 1);
      check($sformatf("len hold%0d out_last", i), out_last, 1);
      check($sformatf("len hold%0d busy", i), busy, 1);
      check_residue($sformatf("len hold%0d", i), 0);
    end
    out_ready = 1'b1;
    tick();
    check("len consumed out_valid", out_valid, 0);
    check("len consumed busy", busy, 0);
    check("len consumed in_ready", in_ready, 0);
    tick();
    check("len idle out_valid", out_valid, 0);
    check_residue("len idle", 0);
    in_valid = 1'b0; x_plus = 1'b0;

    // Overflow then clear
    do_clear();
    do_start(0);
    for (int i = 0; i < 6; i++) begin
      do_step(1, 0);
      check_q($sformatf("ovf step%0d", i), 1);
      check_residue($sformatf("ovf step%0d", i), r_dir[i]);
      check($sformatf("ovf step%0d flag", i), ovf, (i == 5) ? 1 : 0);
    end
    in_valid = 1'b1; x_plus = 1'b1; out_ready = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; x_plus = 1'b0;
    check_residue("after clear", 0);
    check("after clear busy", busy, 0);
    check("after clear ovf", ovf, 1);
    check("after clear out_valid", out_valid, 0);
    check("after clear out_last", out_last, 0);
    do_start(0);
    check("restart ovf", ovf, 0);
    check("restart busy", busy, 1);
    check("restart in_ready", in_ready, 1);

    // Randomized divisions against the model
    for (int dv = 0; dv < 8; dv++) begin
      int d, mr, mov, acc, mq, xv, cyc;
      bit mv, mlast, mbusy, exp_ready;
      d = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
      do_clear();
      do_start(d);
      mr = 0; mov = 0; acc = 0; mq = 0; mv = 0; mlast = 0; mbusy = 1; cyc = 0;
      while (mbusy && cyc < 200) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        x_plus    = $urandom_range(0, 1);
        x_minus   = $urandom_range(0, 1);
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp_ready = (acc < NDIGITS) && (!mv || out_ready);
        check($sformatf("rand%0d c%0d in_ready", dv, cyc), in_ready, exp_ready);
        tick();
        if (in_valid && exp_ready) begin
          xv = int'(x_plus) - int'(x_minus);
          model_step(d, xv, mr, mov, mq);
          acc++;
          mv    = 1;
          mlast = (acc == NDIGITS);
        end else if (mv && out_ready) begin
          if (mlast) mbusy = 0;
          mv    = 0;
          mlast = 0;
        end
        check($sformatf("rand%0d c%0d out_valid", dv, cyc), out_valid, mv);
        if (mv) begin
          check_q($sformatf("rand%0d c%0d", dv, cyc), mq);
          check($sformatf("rand%0d c%0d out_last", dv, cyc), out_last, mlast);
        end
        check_residue($sformatf("rand%0d c%0d", dv, cyc), mr);
        check($sformatf("rand%0d c%0d ovf", dv, cyc), ovf, mov);
        check($sformatf("rand%0d c%0d busy", dv, cyc), busy, mbusy);
        cyc++;
      end
      if (mbusy) check($sformatf("rand%0d cycle budget", dv), 0, 1);
      in_valid = 1'b0; x_plus = 1'b0; x_minus = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
